tx_phy_ctrl: RTL
================

Name: tx_phy_ctrl

Overview:
Bring-up sequencer and data gate for the HPIO native-PHY TX lane.
- Holds the PHY in reset until enabled, then waits for PLL lock, reset sequence done and delay-ready on both byte groups (bsc3/bsc4).
- Enables VTC, sends a training pattern, then passes source data (e.g. the counter data generator) onto data_from_fabric.
- Retries bring-up on timeout or lock loss; latches a failure after MAX_RETRY retries.

Parameters:
PHY_RST_CYCLES, 16, cycles phy_rst is held high in PHY_RST.
LOCK_TIMEOUT, 4096, max cycles in WAIT_LOCK before retry.
RDY_TIMEOUT, 1024, max cycles in each of WAIT_DLY and WAIT_VTC before retry.
TRAIN_CYCLES, 64, training words sent before RUN.
TRAIN_WORD, 8'h0F, constant training byte.
MAX_RETRY, 3, retries allowed before FAIL.

Ports:
clk  in  1  fabric clock (same clock as the PHY fabric data interface).
rst_n  in  1  asynchronous active-low reset.
start  in  1  level enable; low forces IDLE.
pll0_locked  in  1  PHY PLL lock.
rst_seq_done  in  1  PHY reset sequence complete.
dly_rdy_bsc3, dly_rdy_bsc4  in  1 each  delay-ready per byte group.
vtc_rdy_bsc3, vtc_rdy_bsc4  in  1 each  VTC-ready per byte group.
phy_rst  out  1  PHY reset request.
en_vtc_bsc3, en_vtc_bsc4  out  1 each  VTC enable.
src_data  in  8  payload byte.
src_valid  in  1  payload valid.
src_ready  out  1  payload accepted this cycle.
tx_data  out  8  to data_from_fabric of the data lane.
link_up  out  1  high in RUN.
link_fail  out  1  high in FAIL.
retry_cnt  out  2  retries consumed.
state_dbg  out  3  current state encoding.

Behaviour:
- Reset values: state = IDLE, phy_rst = 1, en_vtc_* = 0, src_ready = 0, tx_data = 8'h00 (IDLE_WORD), link_up = 0, link_fail = 0, retry_cnt = 0.
- All outputs are registered. Each output decodes the next state, so its value is valid in the same cycle the state takes effect.
- A single timer counts up from 0 on every state entry. Timer width is clog2 of the largest of PHY_RST_CYCLES, LOCK_TIMEOUT, RDY_TIMEOUT and TRAIN_CYCLES, plus 1.
- Priority 1: start == 0 in any state means IDLE next cycle and retry_cnt cleared.
- IDLE: phy_rst = 1. start == 1 moves to PHY_RST next cycle.
- PHY_RST: phy_rst = 1 for exactly PHY_RST_CYCLES cycles, then WAIT_LOCK.
- WAIT_LOCK: phy_rst = 0.
  - pll0_locked && rst_seq_done → WAIT_DLY.
  - timer == LOCK_TIMEOUT-1 → RETRY action.
- WAIT_DLY: both dly_rdy → WAIT_VTC; timeout at RDY_TIMEOUT → RETRY.
- WAIT_VTC: en_vtc_* = 1 from entry onward; both vtc_rdy → TRAIN; timeout → RETRY.
- TRAIN: tx_data = TRAIN_WORD for exactly TRAIN_CYCLES cycles, then RUN.
- RUN: link_up = 1, src_ready = 1.
  - src_valid at cycle n → tx_data = src_data at n+1; otherwise tx_data = 8'h00.
- Lock loss: pll0_locked == 0 in WAIT_DLY, WAIT_VTC, TRAIN or RUN → RETRY immediately; link_up and src_ready drop the next cycle.
- RETRY action:
  - retry_cnt == MAX_RETRY → FAIL.
  - Otherwise retry_cnt++ and go to PHY_RST. en_vtc_* = 0, tx_data = 8'h00.
- FAIL: phy_rst = 1, link_fail = 1; exits only via start == 0.
- Simultaneous events: the ready condition wins over timeout in the same cycle. Lock loss wins over TRAIN completion.
- retry_cnt saturates and never wraps. It is cleared only in IDLE and on reset.

Optional Feature:
TX_PHY_CTRL_PRBS_EN
- Defined: TRAIN sends PRBS7 (x^7+x^6+1) instead of TRAIN_WORD.
  - LFSR is seeded 7'h7F on TRAIN entry and advances 8 bits per cycle.
  - tx_data[7] carries the first bit generated.
- Undefined: constant TRAIN_WORD; no LFSR logic is synthesised.

Decomposition:
- Package tx_phy_ctrl_pkg holds:
  - state enum: IDLE=0, PHY_RST=1, WAIT_LOCK=2, WAIT_DLY=3, WAIT_VTC=4, TRAIN=5, RUN=6, FAIL=7;
  - IDLE_WORD = 8'h00;
  - PRBS7 seed and taps.
- Sub-module tx_prbs7_gen (8-bit-per-clock LFSR) is instantiated only under TX_PHY_CTRL_PRBS_EN.

Test Plan:
Bench parameters: PHY_RST_CYCLES=4, LOCK_TIMEOUT=20, RDY_TIMEOUT=10, TRAIN_CYCLES=8.
1. Nominal: start=1 at cycle 0, all ready inputs high.
   → phy_rst high for cycles 1–4, en_vtc at cycle 7, tx_data = 8'h0F for 8 cycles, link_up at cycle 16.
   → src_data 0x00..0xFF counter appears on tx_data one cycle delayed.
2. Lock timeout: pll0_locked held 0.
   → retry_cnt steps 1, 2, 3; link_fail = 1 after the 4th timeout.
   → start=0 returns to IDLE with retry_cnt = 0.
3. Lock loss in RUN: drop pll0_locked for 1 cycle.
   → link_up = 0 the next cycle, state_dbg = PHY_RST, retry_cnt = 1, tx_data = 8'h00.
4. Ready and timeout coincide: vtc_rdy rises exactly at timer = 9 in WAIT_VTC → TRAIN, retry_cnt unchanged.
5. src_valid gaps in RUN: valid pattern 1,0,1 with data 0x11, 0x22, 0x33 → tx_data 0x11, 0x00, 0x33.
6. Async reset in TRAIN: assert rst_n=0 mid-cycle → all outputs immediately at reset values; with PRBS_EN the first TRAIN word after re-entry matches the seed-7'h7F model.

Source files
------------

// File: rtl/tx_phy_ctrl_pkg.sv
// Shared types and constants for the HPIO TX-lane bring-up sequencer.
// Holds the state encoding, the idle word and the PRBS7 generator step function.
package tx_phy_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PHY_RST   = 3'd1,
        WAIT_LOCK = 3'd2,
        WAIT_DLY  = 3'd3,
        WAIT_VTC  = 3'd4,
        TRAIN     = 3'd5,
        RUN       = 3'd6,
        FAIL      = 3'd7
    } state_t;

    localparam logic [7:0] IDLE_WORD  = 8'h00;
    localparam logic [6:0] PRBS7_SEED = 7'h7F;
    localparam logic [6:0] PRBS7_TAPS = 7'b110_0000;

    // Eight PRBS7 steps; returns {next_lfsr, word}, first generated bit in word[7].
    function automatic logic [14:0] prbs7_step8(input logic [6:0] seed);
        logic [6:0] lfsr;
        logic [7:0] word;
        logic       fb;
        lfsr = seed;
        word = '0;
        for (int i = 7; i >= 0; i--) begin
            fb      = ^(lfsr & PRBS7_TAPS);
            word[i] = fb;
            lfsr    = {lfsr[5:0], fb};
        end
        return {lfsr, word};
    endfunction

endpackage

// File: rtl/tx_prbs7_gen.sv
// 8-bit-per-clock PRBS7 (x^7+x^6+1) source for the TRAIN pattern.
// load restarts from the seed and emits its first word in the same cycle.
module tx_prbs7_gen
    import tx_phy_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       advance,
    output logic [7:0] word
);

    logic [6:0]  lfsr;
    logic [14:0] step;

    always_comb step = prbs7_step8(load ? PRBS7_SEED : lfsr);

    assign word = step[7:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lfsr <= PRBS7_SEED;
        else if (load || advance)
            lfsr <= step[14:8];
    end

endmodule

// File: rtl/tx_phy_ctrl.sv
// Bring-up sequencer and data gate for the HPIO native-PHY TX lane.
// Define TX_PHY_CTRL_PRBS_EN to train with PRBS7 instead of the constant TRAIN_WORD.
module tx_phy_ctrl
    import tx_phy_ctrl_pkg::*;
#(
    parameter int         PHY_RST_CYCLES = 16,
    parameter int         LOCK_TIMEOUT   = 4096,
    parameter int         RDY_TIMEOUT    = 1024,
    parameter int         TRAIN_CYCLES   = 64,
    parameter logic [7:0] TRAIN_WORD     = 8'h0F,
    parameter int         MAX_RETRY      = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       pll0_locked,
    input  logic       rst_seq_done,
    input  logic       dly_rdy_bsc3,
    input  logic       dly_rdy_bsc4,
    input  logic       vtc_rdy_bsc3,
    input  logic       vtc_rdy_bsc4,
    output logic       phy_rst,
    output logic       en_vtc_bsc3,
    output logic       en_vtc_bsc4,
    input  logic [7:0] src_data,
    input  logic       src_valid,
    output logic       src_ready,
    output logic [7:0] tx_data,
    output logic       link_up,
    output logic       link_fail,
    output logic [1:0] retry_cnt,
    output logic [2:0] state_dbg
);

    localparam int T_MAX_A = (PHY_RST_CYCLES > LOCK_TIMEOUT) ? PHY_RST_CYCLES : LOCK_TIMEOUT;
    localparam int T_MAX_B = (RDY_TIMEOUT > TRAIN_CYCLES) ? RDY_TIMEOUT : TRAIN_CYCLES;
    localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
    localparam int TW      = $clog2(T_MAX) + 1;

    localparam logic [TW-1:0] RST_END   = TW'(PHY_RST_CYCLES - 1);
    localparam logic [TW-1:0] LOCK_END  = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] RDY_END   = TW'(RDY_TIMEOUT - 1);
    localparam logic [TW-1:0] TRAIN_END = TW'(TRAIN_CYCLES - 1);
    localparam logic [1:0]    RETRY_LIM = 2'(MAX_RETRY);

    state_t        state, nxt;
    logic [TW-1:0] timer;
    logic          do_retry;
    logic [7:0]    train_word;

`ifdef TX_PHY_CTRL_PRBS_EN
    tx_prbs7_gen u_prbs (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (nxt == TRAIN && state != TRAIN),
        .advance (nxt == TRAIN),
        .word    (train_word)
    );
`else
    assign train_word = TRAIN_WORD;
`endif

    // Ready beats timeout; lock loss beats everything except start going low.
    always_comb begin
        nxt      = state;
        do_retry = 1'b0;
        case (state)
            IDLE:      nxt = PHY_RST;
            PHY_RST:   if (timer == RST_END) nxt = WAIT_LOCK;
            WAIT_LOCK: begin
                if (pll0_locked && rst_seq_done) nxt = WAIT_DLY;
                else if (timer == LOCK_END)      do_retry = 1'b1;
            end
            WAIT_DLY: begin
                if (!pll0_locked)                      do_retry = 1'b1;
                else if (dly_rdy_bsc3 && dly_rdy_bsc4) nxt = WAIT_VTC;
                else if (timer == RDY_END)             do_retry = 1'b1;
            end
            WAIT_VTC: begin
                if (!pll0_locked)                      do_retry = 1'b1;
                else if (vtc_rdy_bsc3 && vtc_rdy_bsc4) nxt = TRAIN;
                else if (timer == RDY_END)             do_retry = 1'b1;
            end
            TRAIN: begin
                if (!pll0_locked)            do_retry = 1'b1;
                else if (timer == TRAIN_END) nxt = RUN;
            end
            RUN:     if (!pll0_locked) do_retry = 1'b1;
            default: ;
        endcase
        if (do_retry) nxt = (retry_cnt == RETRY_LIM) ? FAIL : PHY_RST;
        if (!start)   nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            timer       <= '0;
            retry_cnt   <= '0;
            phy_rst     <= 1'b1;
            en_vtc_bsc3 <= 1'b0;
            en_vtc_bsc4 <= 1'b0;
            src_ready   <= 1'b0;
            link_up     <= 1'b0;
            link_fail   <= 1'b0;
            tx_data     <= IDLE_WORD;
        end else begin
            state <= nxt;
            timer <= (nxt != state) ? '0 : timer + 1'b1;
            if (nxt == IDLE)
                retry_cnt <= '0;
            else if (do_retry && retry_cnt != RETRY_LIM && retry_cnt != 2'b11)
                retry_cnt <= retry_cnt + 1'b1;
            phy_rst     <= (nxt == IDLE) || (nxt == PHY_RST) || (nxt == FAIL);
            en_vtc_bsc3 <= (nxt == WAIT_VTC) || (nxt == TRAIN) || (nxt == RUN);
            en_vtc_bsc4 <= (nxt == WAIT_VTC) || (nxt == TRAIN) || (nxt == RUN);
            src_ready   <= (nxt == RUN);
            link_up     <= (nxt == RUN);
            link_fail   <= (nxt == FAIL);
            // src_ready is the registered RUN flag, so it marks the accepting cycle.
            case (nxt)
                TRAIN:   tx_data <= train_word;
                RUN:     tx_data <= (src_ready && src_valid) ? src_data : IDLE_WORD;
                default: tx_data <= IDLE_WORD;
            endcase
        end
    end

    assign state_dbg = state;

endmodule
